// File: rtl/commutation_request_conditioner_pkg.sv
// Shared definitions for the commutation request conditioner and the commutation FSM it feeds:
// load codes, request-FSM state encoding and default parameter values.
package commutation_request_conditioner_pkg;

  // Input-phase load codes as seen on load_req and DesiredLoad
  localparam logic [1:0] NUL = 2'b00;
  localparam logic [1:0] LAA = 2'b01;
  localparam logic [1:0] LBB = 2'b10;
  localparam logic [1:0] LCC = 2'b11;

  // Default parameter values shared by every per-phase instance
  localparam int DEF_ADC_W       = 12;
  localparam int DEF_HYST        = 16;
  localparam int DEF_DEBOUNCE    = 4;
  localparam int DEF_MIN_DWELL   = 8;
  localparam int DEF_COMMUTE_CYC = 4;

  // Request FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMMUTE = 2'd1,
    ST_HOLD    = 2'd2
  } req_state_e;

  // True for any real load code, false for the "no request" code
  function automatic logic is_load(input logic [1:0] code);
    return (code == LAA) || (code == LBB) || (code == LCC);
  endfunction

endpackage

// File: rtl/commutation_request_conditioner_sign_debounce.sv
// Hysteretic, debounced current-sign detector with a freeze input.
// A flip is qualified once the candidate sign has disagreed with the held sign for DEBOUNCE
// consecutive valid samples; it is applied on the first cycle that is not frozen.
module commutation_request_conditioner_sign_debounce
  import commutation_request_conditioner_pkg::*;
#(
  parameter int ADC_W    = DEF_ADC_W,
  parameter int HYST     = DEF_HYST,
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic signed [ADC_W-1:0] i_sample,
  input  logic                    freeze,
  output logic                    CurrentSign,
  output logic                    sign_valid,
  output logic                    flip_qual
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic signed [ADC_W-1:0] HYST_POS = ADC_W'(HYST);
  localparam logic signed [ADC_W-1:0] HYST_NEG = -HYST_POS;

  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] neg_cnt;
  logic          above;
  logic          below;
  logic          cand;
  logic          apply_flip;
  logic          neg_run_done;

  // Signed full-width comparisons against the hysteresis window
  assign above = i_sample > HYST_POS;
  assign below = i_sample < HYST_NEG;

  // Inside the window the candidate simply agrees with the held sign
  assign cand = above ? 1'b1 : (below ? 1'b0 : CurrentSign);

  assign flip_qual    = (deb_cnt == DW'(DEBOUNCE));
  assign apply_flip   = flip_qual && !freeze;
  assign neg_run_done = sample_valid && below && (neg_cnt == DW'(DEBOUNCE - 1));

  // Held sign and debounce counter; a qualified flip waits saturated while frozen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      CurrentSign <= 1'b0;
      deb_cnt     <= '0;
    end else if (apply_flip) begin
      CurrentSign <= ~CurrentSign;
      deb_cnt     <= '0;
    end else if (sample_valid) begin
      if (cand == CurrentSign) begin
        deb_cnt <= '0;
      end else if (!flip_qual) begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Run length of consecutive clearly-negative samples, used only to qualify the reset sign
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_cnt <= '0;
    end else if (sample_valid) begin
      if (!below) begin
        neg_cnt <= '0;
      end else if (neg_cnt < DW'(DEBOUNCE)) begin
        neg_cnt <= neg_cnt + 1'b1;
      end
    end
  end

  // Sign becomes trustworthy after the first applied flip or a full negative run; sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_valid <= 1'b0;
    end else if (apply_flip || neg_run_done) begin
      sign_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/commutation_request_conditioner.sv
// Per-output-phase conditioner in front of the safe-commutation FSM.
// Produces a debounced current sign and a dwell-qualified load request, guaranteeing that
// load and sign never change on the same edge and that the sign is frozen while a load change
// is in flight.
module commutation_request_conditioner
  import commutation_request_conditioner_pkg::*;
#(
  parameter int ADC_W       = DEF_ADC_W,
  parameter int HYST        = DEF_HYST,
  parameter int DEBOUNCE    = DEF_DEBOUNCE,
  parameter int MIN_DWELL   = DEF_MIN_DWELL,
  parameter int COMMUTE_CYC = DEF_COMMUTE_CYC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic signed [ADC_W-1:0] i_sample,
  input  logic [1:0]              load_req,
  output logic [1:0]              DesiredLoad,
  output logic                    CurrentSign,
  output logic                    sign_valid,
  output logic                    busy,
  output logic                    req_dropped
);

  localparam int CW  = $clog2(COMMUTE_CYC + 1);
  localparam int DWW = $clog2(MIN_DWELL + 1);

  req_state_e     state_q;
  req_state_e     state_d;
  logic [1:0]     pending_q;
  logic [1:0]     pending_d;
  logic [1:0]     desired_d;
  logic           dropped_d;
  logic [CW-1:0]  commute_cnt_q;
  logic [CW-1:0]  commute_cnt_d;
  logic [DWW-1:0] dwell_cnt_q;
  logic [DWW-1:0] dwell_cnt_d;
  logic           launch;

  logic           flip_qual;
  logic           new_req;
  logic [1:0]     issue_code;
  logic           can_issue;

  // Sign is frozen for exactly the cycles the commutation FSM is switching
  assign busy = (state_q == ST_COMMUTE);

  commutation_request_conditioner_sign_debounce #(
    .ADC_W    (ADC_W),
    .HYST     (HYST),
    .DEBOUNCE (DEBOUNCE)
  ) u_sign (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .i_sample     (i_sample),
    .freeze       (busy),
    .CurrentSign  (CurrentSign),
    .sign_valid   (sign_valid),
    .flip_qual    (flip_qual)
  );

  // A live request bypasses the pending register so an idle channel answers in one cycle.
  // A qualified sign flip outside COMMUTE always takes the edge, pushing the load change back one cycle.
  assign new_req    = is_load(load_req) && (load_req != DesiredLoad);
  assign issue_code = new_req ? load_req : pending_q;
  assign can_issue  = is_load(issue_code) && !flip_qual;

  // Request FSM state, pending slot, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pending_q     <= NUL;
      DesiredLoad   <= NUL;
      req_dropped   <= 1'b0;
      commute_cnt_q <= '0;
      dwell_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      DesiredLoad   <= desired_d;
      req_dropped   <= dropped_d;
      commute_cnt_q <= commute_cnt_d;
      dwell_cnt_q   <= dwell_cnt_d;
    end
  end

  // Next-state logic: capture requests, time the commutation and dwell, launch the next load
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    desired_d     = DesiredLoad;
    dropped_d     = 1'b0;
    commute_cnt_d = commute_cnt_q;
    dwell_cnt_d   = dwell_cnt_q;
    launch        = 1'b0;

    if (new_req) begin
      pending_d = load_req;
      if (is_load(pending_q) && (pending_q != load_req)) begin
        dropped_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (sign_valid && can_issue) begin
          launch = 1'b1;
        end
      end
      ST_COMMUTE: begin
        if (commute_cnt_q == CW'(COMMUTE_CYC - 1)) begin
          state_d     = ST_HOLD;
          dwell_cnt_d = DWW'(MIN_DWELL);
        end else begin
          commute_cnt_d = commute_cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (dwell_cnt_q != '0) begin
          dwell_cnt_d = dwell_cnt_q - 1'b1;
        end else if (can_issue) begin
          launch = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (launch) begin
      desired_d     = issue_code;
      pending_d     = NUL;
      state_d       = ST_COMMUTE;
      commute_cnt_d = '0;
    end
  end

endmodule
